// File: rtl/mem_arbiter.sv
// Two-port Avalon-MM arbiter: serializes port D (read/write) and port I (read-only)
// onto one master, round-robin on contention, one outstanding transaction at a time.
module mem_arbiter #(
    parameter int ADDR_W     = 26,
    parameter int DATA_W     = 128,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              avl_wait,
    input  logic              avl_readdatavalid,
    input  logic [DATA_W-1:0] avl_readdata,
    output logic              avl_read,
    output logic              avl_write,
    output logic [ADDR_W-1:0] avl_address,
    output logic [DATA_W-1:0] avl_writedata,
    output logic              busy,
    output logic              grant_id,
    output logic              timeout_flag
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

    localparam logic [7:0] TO_LIMIT = 8'(RD_TIMEOUT);

    state_t     state, state_nxt;
    logic       last_grant;
    logic [7:0] rd_cnt;
    logic       grant_sel;
    logic       start;
    logic       cmd_accept;
    logic       rd_ok;
    logic       rd_to;
    logic       done_en;

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        cmd_accept = 1'b0;
        rd_ok      = 1'b0;
        rd_to      = 1'b0;
        done_en    = 1'b0;
        // A tie goes to whichever port was not served last
        grant_sel  = ~last_grant;
        if (d_req && !i_req)
            grant_sel = 1'b0;
        else if (!d_req && i_req)
            grant_sel = 1'b1;

        case (state)
            IDLE: begin
                if (d_req || i_req) begin
                    start     = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!avl_wait) begin
                    cmd_accept = 1'b1;
                    if (avl_write) begin
                        done_en   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                if (avl_readdatavalid) begin
                    rd_ok     = 1'b1;
                    done_en   = 1'b1;
                    state_nxt = DONE;
                end else if (rd_cnt == TO_LIMIT) begin
                    rd_to     = 1'b1;
                    done_en   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            grant_id     <= 1'b0;
            avl_read     <= 1'b0;
            avl_write    <= 1'b0;
            d_ack        <= 1'b0;
            i_ack        <= 1'b0;
            timeout_flag <= 1'b0;
            rd_cnt       <= 8'd0;
        end else begin
            state <= state_nxt;
            d_ack <= done_en & ~grant_id;
            i_ack <= done_en & grant_id;
            if (start) begin
                grant_id  <= grant_sel;
                avl_read  <= grant_sel | ~d_we;
                avl_write <= ~grant_sel & d_we;
            end
            if (cmd_accept) begin
                avl_read  <= 1'b0;
                avl_write <= 1'b0;
                rd_cnt    <= 8'd0;
            end
            if (state == WAIT_RD && !done_en)
                rd_cnt <= rd_cnt + 8'd1;
            if (rd_to)
                timeout_flag <= 1'b1;
            if (state == DONE)
                last_grant <= grant_id;
        end
    end

    // Command and read-return registers; rdata of the idle port is never touched
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            avl_address   <= '0;
            avl_writedata <= '0;
            d_rdata       <= '0;
            i_rdata       <= '0;
        end else begin
            if (start) begin
                avl_address <= grant_sel ? i_addr : d_addr;
                if (!grant_sel)
                    avl_writedata <= d_wdata;
            end
            if (rd_ok || rd_to) begin
                if (grant_id)
                    i_rdata <= rd_to ? '0 : avl_readdata;
                else
                    d_rdata <= rd_to ? '0 : avl_readdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 128;
    localparam int RT     = 4;

    logic              iCLK = 1'b0;
    logic              iRST_n = 1'b0;
    logic              d_req = 1'b0, d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;
    logic              avl_wait = 1'b0, avl_readdatavalid = 1'b0;
    logic [DATA_W-1:0] avl_readdata = '0;
    logic              avl_read, avl_write;
    logic [ADDR_W-1:0] avl_address;
    logic [DATA_W-1:0] avl_writedata;
    logic              busy, grant_id, timeout_flag;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_TIMEOUT(RT)) dut (
        .iCLK(iCLK), .iRST_n(iRST_n),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .avl_wait(avl_wait), .avl_readdatavalid(avl_readdatavalid),
        .avl_readdata(avl_readdata), .avl_read(avl_read), .avl_write(avl_write),
        .avl_address(avl_address), .avl_writedata(avl_writedata),
        .busy(busy), .grant_id(grant_id), .timeout_flag(timeout_flag)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: who was served last, what each port last received, sticky timeout
    logic              last_m;
    logic [DATA_W-1:0] d_rdata_m, i_rdata_m;
    logic              to_m;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        last_m    = 1'b1;
        d_rdata_m = '0;
        i_rdata_m = '0;
        to_m      = 1'b0;
    endtask

    task automatic check_zero();
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_read", avl_read, 0);
        check("rst_write", avl_write, 0);
        check("rst_d_ack", d_ack, 0);
        check("rst_i_ack", i_ack, 0);
        check("rst_tflag", timeout_flag, 0);
        check("rst_addr", avl_address, 0);
        check("rst_wdata", avl_writedata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_i_rdata", i_rdata, 0);
    endtask

    task automatic do_reset();
        iRST_n = 1'b0;
        d_req = 1'b0; i_req = 1'b0; avl_wait = 1'b0; avl_readdatavalid = 1'b0;
        repeat (2) @(posedge iCLK);
        #1 check_zero();
        @(negedge iCLK);
        iRST_n = 1'b1;
        model_reset();
        @(posedge iCLK);
        #1;
    endtask

    // Entered #1 after an edge with the arbiter idle and requests already driven.
    // w = waitrequest cycles, l = readdatavalid latency after command acceptance.
    task automatic do_txn(input int w, input int l, input logic [DATA_W-1:0] rd,
                          output logic gp);
        logic              we, tout;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] wd;
        int                t_ack;
        gp    = (d_req && i_req) ? ~last_m : (d_req ? 1'b0 : 1'b1);
        we    = gp ? 1'b0 : d_we;
        a     = gp ? i_addr : d_addr;
        wd    = d_wdata;
        tout  = !we && (l > RT + 1);
        t_ack = 2 + w + (we ? 0 : (tout ? RT + 1 : l));
        check("idle_busy", busy, 0);
        for (int t = 1; t <= t_ack + 1; t++) begin
            @(posedge iCLK);
            #1;
            avl_wait          = (t <= w);
            avl_readdatavalid = 1'b0;
            avl_readdata      = rand_data();
            if (!we && t == 1 + w + l) begin
                avl_readdatavalid = 1'b1;
                avl_readdata      = rd;
            end else if (t <= w + 1 && $urandom_range(0, 3) == 0) begin
                avl_readdatavalid = 1'b1;
            end
            if (t <= t_ack) begin
                check("busy", busy, 1);
                check("grant_id", grant_id, gp);
                check("avl_read", avl_read, (t <= w + 1) && !we);
                check("avl_write", avl_write, (t <= w + 1) && we);
                if (t <= w + 1) begin
                    check("avl_address", avl_address, a);
                    if (we) check("avl_writedata", avl_writedata, wd);
                end
            end else begin
                check("busy_after", busy, 0);
            end
            check("d_ack", d_ack, (t == t_ack) && !gp);
            check("i_ack", i_ack, (t == t_ack) && gp);
            if (t == t_ack) begin
                if (!we) begin
                    if (gp) i_rdata_m = tout ? '0 : rd;
                    else    d_rdata_m = tout ? '0 : rd;
                end
                to_m   = to_m | tout;
                last_m = gp;
                check("d_rdata", d_rdata, d_rdata_m);
                check("i_rdata", i_rdata, i_rdata_m);
                check("timeout_flag", timeout_flag, to_m);
                if (gp) i_req = 1'b0;
                else    d_req = 1'b0;
            end
        end
        avl_wait          = 1'b0;
        avl_readdatavalid = 1'b0;
    endtask

    logic gp;

    initial begin
        model_reset();
        do_reset();

        // Continuous reads on both ports from reset alternate D, I, D, I
        for (int k = 0; k < 4; k++) begin
            d_req = 1'b1; d_we = 1'b0; d_addr = ADDR_W'(32'h100 + k);
            i_req = 1'b1; i_addr = ADDR_W'(32'h200 + k);
            do_txn($urandom_range(0, 2), $urandom_range(1, 3), rand_data(), gp);
            check("rr_order", gp, k % 2);
        end
        d_req = 1'b0; i_req = 1'b0;
        @(posedge iCLK);
        #1;

        // Single D write
        d_req = 1'b1; d_we = 1'b1; d_addr = ADDR_W'(32'h10); d_wdata = {16{8'hA5}};
        do_txn(0, 1, '0, gp);
        check("wr_grant", gp, 0);

        // I read with three wait cycles and data two cycles after acceptance
        i_req = 1'b1; i_addr = ADDR_W'(32'h20);
        do_txn(3, 2, 128'h1234, gp);
        check("rd_i_rdata", i_rdata, 128'h1234);

        // D read that never sees readdatavalid, then a normal read
        d_req = 1'b1; d_we = 1'b0; d_addr = ADDR_W'(32'h33);
        do_txn(0, 50, '0, gp);
        check("to_rdata", d_rdata, 0);
        check("to_flag", timeout_flag, 1);
        d_req = 1'b1; d_we = 1'b0; d_addr = ADDR_W'(32'h34);
        do_txn(1, 2, 128'hBEEF, gp);
        check("to_sticky", timeout_flag, 1);

        // Reset while waiting for read data
        d_req = 1'b1; d_we = 1'b0; d_addr = ADDR_W'(32'h44);
        @(posedge iCLK);
        #1 avl_wait = 1'b0;
        @(posedge iCLK);
        #1 check("mid_busy", busy, 1);
        iRST_n = 1'b0;
        d_req  = 1'b0;
        #1 check_zero();
        @(negedge iCLK);
        iRST_n = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            @(posedge iCLK);
            #1;
            check("late_d_ack", d_ack, 0);
            check("late_i_ack", i_ack, 0);
            check("late_busy", busy, 0);
            check("late_d_rdata", d_rdata, 0);
            avl_readdatavalid = (k < 2);
            avl_readdata      = rand_data();
        end
        avl_readdatavalid = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = ADDR_W'(32'h55);
        i_req = 1'b1; i_addr = ADDR_W'(32'h66);
        do_txn(0, 1, 128'hCAFE, gp);
        check("post_rst_grant", gp, 0);

        // Random traffic
        for (int k = 0; k < 150; k++) begin
            if (!d_req && $urandom_range(0, 1) == 1) begin
                d_req = 1'b1; d_we = 1'($urandom); d_addr = ADDR_W'($urandom);
                d_wdata = rand_data();
            end
            if (!i_req && $urandom_range(0, 1) == 1) begin
                i_req = 1'b1; i_addr = ADDR_W'($urandom);
            end
            if (!d_req && !i_req) begin
                i_req = 1'b1; i_addr = ADDR_W'($urandom);
            end
            do_txn($urandom_range(0, 3),
                   ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(1, 5),
                   rand_data(), gp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single Avalon-MM memory master between the CPU data port (port D) and the instruction-fetch port (port I). It serializes requests, one outstanding transaction at a time, and uses round-robin priority on contention. It handles the Avalon wait/readdatavalid handshake and returns read data with a one-cycle acknowledge pulse. It sits between the CPU core and the SDRAM Avalon slave, replacing direct CPU-to-memory access.

## Interface
- ADDR_W, 26, word address width (128-bit words)
- DATA_W, 128, data width
- RD_TIMEOUT, 255, max cycles waiting for readdatavalid (1..255, 8-bit counter)
- iCLK  in  1  clock; all logic rising-edge
- iRST_n  in  1  asynchronous, active-low reset
- d_req  in  1  port D request; held with d_we/d_addr/d_wdata stable until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  port D address
- d_wdata  in  DATA_W  port D write data
- d_rdata  out  DATA_W  port D read data, valid when d_ack=1
- d_ack  out  1  one-cycle completion pulse
- i_req  in  1  port I read request (read-only port)
- i_addr  in  ADDR_W  port I address
- i_rdata  out  DATA_W  port I read data, valid when i_ack=1
- i_ack  out  1  one-cycle completion pulse
- avl_wait  in  1  slave waitrequest
- avl_readdatavalid  in  1  read data valid
- avl_readdata  in  DATA_W  read data
- avl_read  out  1  read command
- avl_write  out  1  write command
- avl_address  out  ADDR_W  address
- avl_writedata  out  DATA_W  write data
- busy  out  1  1 when state != IDLE
- grant_id  out  1  0 = port D owns bus, 1 = port I (valid while busy)
- timeout_flag  out  1  sticky; set on read timeout, cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE: sample d_req, i_req. If only one is high, grant it. If both are high, grant the port not granted last (last_grant register, reset = I, so the first tie goes to D). Latch addr, we (forced 0 for I) and wdata into avl_* registers. Assert avl_read or avl_write. Go to ISSUE. With no request, remain in IDLE.
- ISSUE: hold avl_read/avl_write and address/data while avl_wait=1.
  - avl_wait=0 on a write: deassert avl_write, go to DONE.
  - avl_wait=0 on a read: deassert avl_read, clear the timeout counter, go to WAIT_RD.
- WAIT_RD:
  - On avl_readdatavalid=1: capture avl_readdata into the granted port's rdata register, go to DONE.
  - Otherwise increment the counter. When it reaches RD_TIMEOUT: set timeout_flag, load rdata = 0, go to DONE.
- DONE: drive the granted port's ack=1 for exactly one cycle, update last_grant, go to IDLE.
- rdata registers hold their value until the next completion on the same port. The non-granted port's rdata never changes.
- A requester must drop req in the cycle after ack. A req still high when IDLE next samples it is treated as a new request.
- avl_readdatavalid outside WAIT_RD is ignored.
- Requests never abort. A deasserted req during ISSUE/WAIT_RD is ignored and the transaction completes with ack.
- Reset mid-transaction: every output goes to its reset value immediately. The pending transaction is dropped with no ack.
- Reset values: avl_read, avl_write, d_ack, i_ack, busy, grant_id, timeout_flag = 0. avl_address, avl_writedata, d_rdata, i_rdata = 0. State = IDLE, last_grant = I.

## Timing
- Request seen high at edge n → avl_read/avl_write high in cycle n+1.
- Write with avl_wait=0 at n+1: ack in cycle n+2 (2-cycle minimum latency).
- Read with avl_wait=0 at n+1 and readdatavalid in cycle n+1+L (L ≥ 1): ack in cycle n+2+L, with rdata valid in the same cycle.
- Each avl_wait cycle adds one cycle to latency. The command is held unchanged throughout.
- Back-to-back: IDLE follows DONE. The next grant issues one cycle after the ack cycle. The bus is idle for ≥1 cycle between transactions.
- Timeout: ack in the cycle after the counter reaches RD_TIMEOUT (RD_TIMEOUT+1 cycles after entering WAIT_RD).

## Test plan
- Single D write (addr 0x10, data 0xA5..A5, avl_wait=0) → avl_write=1 for exactly 1 cycle with matching addr/data; d_ack at req+2; i_ack never fires.
- I read at 0x20, avl_wait=1 for 3 cycles, readdatavalid 2 cycles after acceptance with data 0x1234 → avl_read held 4 cycles; i_rdata=0x1234 with i_ack at the expected cycle; d_rdata unchanged.
- Both ports request reads continuously from reset, 4 transactions → grant order D, I, D, I; grant_id matches; each ack occurs once per transaction.
- RD_TIMEOUT=4, D read, readdatavalid never asserted → d_ack after 5 WAIT_RD cycles; d_rdata=0; timeout_flag=1 and stays set across a following successful read.
- Reset pulsed while in WAIT_RD → all outputs are 0 during reset; no ack afterwards; a late readdatavalid is ignored; the next request after reset completes normally with D-first tie priority.
